prog_sequencer: RTL and testbench

Run-control sequencer for the program counter. It owns the PC's init, jump_en, branch_en and destination inputs, and maps per-instruction decode flags and datapath stall requests onto them. It provides a start/done/ack handshake to the testbench or host, and counts executed cycles and retired instructions. It sits between the instruction decoder and the PC in the top level.

---
 rtl/prog_sequencer.sv | 135 +++++++++++++
 tb/tb_prog_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// prog_sequencer: IDLE/RUN/DONE run-control for the PC with cycle/retire counters.
// Optional macro SEQ_WATCHDOG_EN adds a RUN-cycle watchdog that ends the run with timeout=1.
`default_nettype none

module prog_sequencer #(
  parameter int PC_W       = 10,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 4096
) (
  input  logic             CLK,
  input  logic             init,
  input  logic             start,
  input  logic             ack,
  input  logic [PC_W-1:0]  pc,
  input  logic             halt,
  input  logic             is_jump,
  input  logic             is_branch,
  input  logic             cond,
  input  logic [PC_W-1:0]  target,
  input  logic             stall_req,
  output logic             pc_init,
  output logic             jump_en,
  output logic             branch_en,
  output logic [PC_W-1:0]  destination,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             retire,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   wd_hit;

`ifdef SEQ_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);
  logic timeout_q;

  // Halt wins over the watchdog on the same cycle.
  assign wd_hit  = (state == RUN) && !halt && (cycles == WD_LAST);
  assign timeout = timeout_q;
`else
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (init) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_init     = init;
    jump_en     = 1'b0;
    branch_en   = 1'b0;
    destination = target;
    busy        = 1'b0;
    done        = 1'b0;
    retire      = 1'b0;
    case (state)
      IDLE: begin
        pc_init     = 1'b1;
        destination = '0;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (halt) begin
          state_nxt = DONE;
        end else if (stall_req) begin
          jump_en     = 1'b1;
          destination = pc;
        end else if (is_jump) begin
          jump_en = 1'b1;
          retire  = 1'b1;
        end else if (is_branch && cond) begin
          branch_en = 1'b1;
          retire    = 1'b1;
        end else begin
          retire = 1'b1;
        end
        if (wd_hit) state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        jump_en     = 1'b1;
        destination = pc;
        if (ack) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Counters saturate; on the watchdog cycle the cycle count holds at MAX_CYCLES-1.
  always_ff @(posedge CLK) begin
    if (init) begin
      cycles  <= '0;
      retired <= '0;
    end else if (state == IDLE && start) begin
      cycles  <= '0;
      retired <= '0;
    end else if (state == RUN) begin
      if (!wd_hit && cycles != {CNT_W{1'b1}}) cycles <= cycles + 1'b1;
      if (retire && retired != {CNT_W{1'b1}}) retired <= retired + 1'b1;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  always_ff @(posedge CLK) begin
    if (init) begin
      timeout_q <= 1'b0;
    end else if (state == IDLE && start) begin
      timeout_q <= 1'b0;
    end else if (wd_hit) begin
      timeout_q <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: vector table in RUN plus a behavioural PC for sequences.
`default_nettype none

module tb_prog_sequencer;

  localparam int PC_W  = 10;
  localparam int CNT_W = 16;

  logic             CLK = 1'b0;
  logic             init, start, ack, halt_v, is_jump, is_branch, cond, stall_req;
  logic [PC_W-1:0]  pc_v, target;
  logic             pc_init, jump_en, branch_en, busy, done, timeout, retire;
  logic [PC_W-1:0]  destination;
  logic [CNT_W-1:0] cycles, retired;

  logic             use_model;
  logic [PC_W-1:0]  pc_model, halt_at;
  logic [PC_W-1:0]  pc_w;
  logic             halt_w;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  // PC as seen by the sequencer: a simple incrementing/jumping/skipping counter.
  always @(posedge CLK) begin
    if (pc_init)        pc_model <= '0;
    else if (jump_en)   pc_model <= destination;
    else if (branch_en) pc_model <= pc_model + 10'd2;
    else                pc_model <= pc_model + 10'd1;
  end

  assign pc_w   = use_model ? pc_model : pc_v;
  assign halt_w = use_model ? (pc_model > halt_at) : halt_v;

  prog_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W), .MAX_CYCLES(16)) dut (
    .CLK(CLK), .init(init), .start(start), .ack(ack), .pc(pc_w), .halt(halt_w),
    .is_jump(is_jump), .is_branch(is_branch), .cond(cond), .target(target),
    .stall_req(stall_req), .pc_init(pc_init), .jump_en(jump_en), .branch_en(branch_en),
    .destination(destination), .busy(busy), .done(done), .timeout(timeout),
    .retire(retire), .cycles(cycles), .retired(retired)
  );

  typedef struct {
    logic [PC_W-1:0] pc;
    logic            jmp, br, cnd, stl, hlt, st, ak;
    logic [PC_W-1:0] tgt;
    logic            e_je, e_be;
    logic [PC_W-1:0] e_dest;
    logic            e_ret;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_ins();
    start = 0; ack = 0; halt_v = 0; is_jump = 0; is_branch = 0; cond = 0;
    stall_req = 0; pc_v = '0; target = '0;
  endtask

  initial begin
    int exp_cyc, exp_ret, k;
    logic [CNT_W-1:0] c0, r0;

    //           pc  jmp br cnd stl hlt st ak  tgt je be dest ret
    vecs[0] = '{10'd0,  0, 0, 0, 0, 0, 0, 0, 10'd7,  0, 0, 10'd7,  1};
    vecs[1] = '{10'd5,  1, 0, 0, 0, 0, 0, 0, 10'd40, 1, 0, 10'd40, 1};
    vecs[2] = '{10'd40, 0, 1, 1, 0, 0, 0, 0, 10'd3,  0, 1, 10'd3,  1};
    vecs[3] = '{10'd41, 0, 1, 0, 0, 0, 0, 0, 10'd9,  0, 0, 10'd9,  1};
    vecs[4] = '{10'd10, 1, 0, 0, 1, 0, 0, 0, 10'd50, 1, 0, 10'd10, 0};
    vecs[5] = '{10'd10, 0, 1, 1, 1, 0, 0, 0, 10'd51, 1, 0, 10'd10, 0};
    vecs[6] = '{10'd11, 1, 1, 1, 0, 0, 0, 0, 10'd20, 1, 0, 10'd20, 1};
    vecs[7] = '{10'd12, 0, 0, 0, 0, 0, 1, 0, 10'd21, 0, 0, 10'd21, 1};
    vecs[8] = '{10'd13, 0, 0, 0, 0, 0, 0, 1, 10'd22, 0, 0, 10'd22, 1};
    vecs[9] = '{10'd14, 1, 0, 0, 1, 1, 0, 0, 10'd23, 0, 0, 10'd23, 0};

    use_model = 0; halt_at = 10'd1000;
    clear_ins();
    init = 1;
    step(); step();
    chk("reset_pc_init", pc_init, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cycles", cycles, 0);
    chk("reset_retired", retired, 0);
    chk("reset_timeout", timeout, 0);

    init = 0; start = 1; #1;
    chk("idle_pc_init", pc_init, 1);
    chk("idle_dest", destination, 0);
    chk("idle_busy", busy, 0);
    step();
    start = 0; #1;
    chk("run_busy", busy, 1);
    chk("run_pc_init", pc_init, 0);

    exp_cyc = 0; exp_ret = 0;
    for (int i = 0; i < 10; i++) begin
      pc_v = vecs[i].pc; is_jump = vecs[i].jmp; is_branch = vecs[i].br;
      cond = vecs[i].cnd; stall_req = vecs[i].stl; halt_v = vecs[i].hlt;
      start = vecs[i].st; ack = vecs[i].ak; target = vecs[i].tgt;
      #1;
      chk($sformatf("v%0d_jump_en", i), jump_en, vecs[i].e_je);
      chk($sformatf("v%0d_branch_en", i), branch_en, vecs[i].e_be);
      chk($sformatf("v%0d_dest", i), destination, vecs[i].e_dest);
      chk($sformatf("v%0d_retire", i), retire, vecs[i].e_ret);
      chk($sformatf("v%0d_busy", i), busy, 1);
      chk($sformatf("v%0d_cycles", i), cycles, exp_cyc);
      chk($sformatf("v%0d_retired", i), retired, exp_ret);
      exp_cyc++;
      if (vecs[i].e_ret) exp_ret++;
      step();
    end

    clear_ins(); pc_v = 10'd123; #1;
    chk("halt_done", done, 1);
    chk("halt_busy", busy, 0);
    chk("done_jump_en", jump_en, 1);
    chk("done_dest", destination, 123);
    chk("done_branch_en", branch_en, 0);
    chk("done_cycles", cycles, 10);
    chk("done_retired", retired, 7);
    start = 1; step(); start = 0; #1;
    chk("done_ignores_start", done, 1);
    chk("done_counters_hold", cycles, 10);
    ack = 1; step(); ack = 0; #1;
    chk("ack_idle_done", done, 0);
    chk("ack_idle_pc_init", pc_init, 1);
    chk("ack_idle_jump_en", jump_en, 0);

    // Straight-line program halting at pc>84
    use_model = 1; halt_at = 10'd84;
    start = 1; step(); start = 0; #1;
    chk("sl_pc0", pc_w, 0);
    chk("sl_first_retire", retire, 1);
    for (k = 0; k < 200 && !halt_w; k++) step();
    chk("sl_halt_reached", halt_w, 1);
    step();
    chk("sl_done", done, 1);
    chk("sl_retired", retired, 85);
    chk("sl_cycles", cycles, 86);
    ack = 1; step(); ack = 0; #1;
    chk("sl_ack_pc_init", pc_init, 1);
    chk("sl_ack_busy", busy, 0);

    // Stall held three cycles at pc=10
    halt_at = 10'd1000;
    step();
    start = 1; step(); start = 0; #1;
    for (k = 0; k < 50 && pc_w != 10'd10; k++) step();
    chk("st_reach_pc10", pc_w, 10);
    c0 = cycles; r0 = retired;
    stall_req = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("st%0d_pc", i), pc_w, 10);
      chk($sformatf("st%0d_jump_en", i), jump_en, 1);
      chk($sformatf("st%0d_dest", i), destination, 10);
      chk($sformatf("st%0d_retire", i), retire, 0);
      step();
    end
    stall_req = 0; #1;
    chk("st_pc_held", pc_w, 10);
    chk("st_cycles_adv", cycles, c0 + 3);
    chk("st_retired_same", retired, r0);

    // init mid-run at pc=30
    for (k = 0; k < 50 && pc_w != 10'd30; k++) step();
    chk("mid_reach_pc30", pc_w, 30);
    init = 1; step(); init = 0; #1;
    chk("mid_init_busy", busy, 0);
    chk("mid_init_pc_init", pc_init, 1);
    chk("mid_init_pc0", pc_w, 0);
    start = 1; step(); start = 0; #1;
    chk("restart_cycles", cycles, 0);
    chk("restart_retired", retired, 0);
    chk("restart_busy", busy, 1);

    // Infinite self-jump loop
    use_model = 0; pc_v = 10'd3; is_jump = 1; target = 10'd3;
    for (k = 0; k < 30 && busy; k++) step();
`ifdef SEQ_WATCHDOG_EN
    chk("wd_run_len", k, 16);
    chk("wd_done", done, 1);
    chk("wd_timeout", timeout, 1);
    chk("wd_cycles", cycles, 15);
`else
    chk("loop_still_busy", busy, 1);
    chk("loop_timeout", timeout, 0);
    chk("loop_cycles", cycles, 30);
`endif
    clear_ins();
    init = 1; step(); init = 0; #1;
    chk("final_idle_timeout", timeout, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
